rv32i_mc_ctrl: RTL and testbench

//  Multi-cycle RV32I control FSM. It is the issuing end of the ALU interface:
//  it produces ALUOp and the operand selects, and it consumes the ALU Zero flag
//  to resolve branches. It accepts one instruction per handshake, latches it in
//  IR and steps FETCH/DECODE/EXEC/MEM/WB, driving register-file, memory and PC

---
 rtl/rv32i_mc_ctrl_pkg.sv | 83 ++++++++
 rtl/rv32i_dec.sv | 77 +++++++
 rtl/rv32i_mc_ctrl.sv | 139 +++++++++++++
 tb/tb_rv32i_mc_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_mc_ctrl_pkg.sv
// rtl/rv32i_mc_ctrl_pkg.sv - encodings shared by the rv32i multi-cycle controller
package rv32i_mc_ctrl_pkg;

  // ALU operation codes driven on ALUOp
  localparam logic [4:0] aluop_nop  = 5'd0;
  localparam logic [4:0] aluop_lui  = 5'd1;
  localparam logic [4:0] aluop_auipc = 5'd2;
  localparam logic [4:0] aluop_add  = 5'd3;
  localparam logic [4:0] aluop_sub  = 5'd4;
  localparam logic [4:0] aluop_bne  = 5'd5;
  localparam logic [4:0] aluop_blt  = 5'd6;
  localparam logic [4:0] aluop_bge  = 5'd7;
  localparam logic [4:0] aluop_bltu = 5'd8;
  localparam logic [4:0] aluop_bgeu = 5'd9;
  localparam logic [4:0] aluop_slt  = 5'd10;
  localparam logic [4:0] aluop_sltu = 5'd11;
  localparam logic [4:0] aluop_xor  = 5'd12;
  localparam logic [4:0] aluop_or   = 5'd13;
  localparam logic [4:0] aluop_and  = 5'd14;
  localparam logic [4:0] aluop_sll  = 5'd15;
  localparam logic [4:0] aluop_srl  = 5'd16;
  localparam logic [4:0] aluop_sra  = 5'd17;

  // immediate formats driven on EXTOp
  localparam logic [2:0] extop_i = 3'd0;
  localparam logic [2:0] extop_s = 3'd1;
  localparam logic [2:0] extop_b = 3'd2;
  localparam logic [2:0] extop_u = 3'd3;
  localparam logic [2:0] extop_j = 3'd4;

  // write-back source
  localparam logic [1:0] wdsel_alu = 2'd0;
  localparam logic [1:0] wdsel_mem = 2'd1;
  localparam logic [1:0] wdsel_pc4 = 2'd2;

  // next-PC source
  localparam logic [1:0] pcsrc_pc4  = 2'd0;
  localparam logic [1:0] pcsrc_imm  = 2'd1;
  localparam logic [1:0] pcsrc_jalr = 2'd2;

  // RV32I major opcodes
  localparam logic [6:0] opc_op     = 7'b0110011;
  localparam logic [6:0] opc_opimm  = 7'b0010011;
  localparam logic [6:0] opc_load   = 7'b0000011;
  localparam logic [6:0] opc_store  = 7'b0100011;
  localparam logic [6:0] opc_branch = 7'b1100011;
  localparam logic [6:0] opc_jal    = 7'b1101111;
  localparam logic [6:0] opc_jalr   = 7'b1100111;
  localparam logic [6:0] opc_lui    = 7'b0110111;
  localparam logic [6:0] opc_auipc  = 7'b0010111;

  typedef enum logic [2:0] {
    s_fetch, s_decode, s_exec, s_mem, s_wb, s_trap
  } state_t;

  typedef enum logic [3:0] {
    cls_alu, cls_lui, cls_auipc, cls_jal, cls_jalr,
    cls_load, cls_store, cls_branch, cls_ill
  } iclass_t;

  // register/immediate ALU op from funct3; alt selects sub/sra
  function automatic logic [4:0] alu_fn(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'd0:    alu_fn = alt ? aluop_sub : aluop_add;
      3'd1:    alu_fn = aluop_sll;
      3'd2:    alu_fn = aluop_slt;
      3'd3:    alu_fn = aluop_sltu;
      3'd4:    alu_fn = aluop_xor;
      3'd5:    alu_fn = alt ? aluop_sra : aluop_srl;
      3'd6:    alu_fn = aluop_or;
      default: alu_fn = aluop_and;
    endcase
  endfunction

  // classes that produce a register-file result in WB
  function automatic logic rd_writes(input logic [3:0] cls);
    case (cls)
      cls_alu, cls_lui, cls_auipc, cls_jal, cls_jalr, cls_load: rd_writes = 1'b1;
      default: rd_writes = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_dec.sv
// rtl/rv32i_dec.sv - combinational opcode/funct decoder for the rv32i controller
module rv32i_dec
  import rv32i_mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [4:0] aluop,
  output logic       asel,
  output logic       bsel,
  output logic [2:0] extop,
  output logic [3:0] iclass,
  output logic       illegal
);

  // map the instruction to its ALU controls and execution class
  always_comb begin
    aluop   = aluop_nop;
    asel    = 1'b0;
    bsel    = 1'b0;
    extop   = extop_i;
    iclass  = cls_ill;
    illegal = 1'b0;
    case (opcode)
      opc_op: begin
        iclass = cls_alu;
        aluop  = alu_fn(funct3, funct7b5);
      end
      opc_opimm: begin
        // funct7[5] only distinguishes srai from srli; addi never subtracts
        iclass = cls_alu;
        bsel   = 1'b1;
        aluop  = alu_fn(funct3, funct7b5 && (funct3 == 3'd5));
      end
      opc_lui: begin
        iclass = cls_lui;
        aluop  = aluop_lui;
        bsel   = 1'b1;
        extop  = extop_u;
      end
      opc_auipc: begin
        iclass = cls_auipc;
        aluop  = aluop_add;
        asel   = 1'b1;
        bsel   = 1'b1;
        extop  = extop_u;
      end
      opc_jal: begin
        iclass = cls_jal;
        extop  = extop_j;
      end
      opc_jalr: begin
        iclass = cls_jalr;
        aluop  = aluop_add;
        bsel   = 1'b1;
      end
      opc_load: begin
        iclass = cls_load;
        aluop  = aluop_add;
        bsel   = 1'b1;
      end
      opc_store: begin
        iclass = cls_store;
        aluop  = aluop_add;
        bsel   = 1'b1;
        extop  = extop_s;
      end
      opc_branch: begin
        iclass = cls_branch;
        extop  = extop_b;
        aluop  = funct3[2] ? (funct3[1] ? aluop_sltu : aluop_slt) : aluop_sub;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_mc_ctrl.sv
// rtl/rv32i_mc_ctrl.sv - multi-cycle RV32I control FSM with instruction register
module rv32i_mc_ctrl
  import rv32i_mc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_IR        = 32'h00000013,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [31:0] ir,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic [4:0]  ALUOp,
  output logic        ASel,
  output logic        BSel,
  output logic [2:0]  EXTOp,
  output logic        RegWrite,
  output logic [1:0]  WDSel,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        illegal
);

  state_t     state, state_nxt;
  logic [4:0] dec_aluop;
  logic       dec_asel, dec_bsel, dec_illegal;
  logic [2:0] dec_extop;
  logic [3:0] dec_class;
  logic       taken;
  logic       rdy, rw, mr, mw, pcw;

  rv32i_dec u_dec (
    .opcode   (ir[6:0]),
    .funct3   (ir[14:12]),
    .funct7b5 (ir[30]),
    .aluop    (dec_aluop),
    .asel     (dec_asel),
    .bsel     (dec_bsel),
    .extop    (dec_extop),
    .iclass   (dec_class),
    .illegal  (dec_illegal)
  );

  // beq/bge/bgeu take on Zero, bne/blt/bltu on !Zero
  assign taken = Zero ^ (ir[12] ^ ir[14]);

  // state, instruction register and sticky illegal flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= s_fetch;
      ir      <= RESET_IR;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == s_fetch && instr_valid) ir <= instr;
      if (state != s_trap && state_nxt == s_trap) illegal <= 1'b1;
    end
  end

  // next state and datapath controls; Zero and mem_ready reach outputs only
  // where a branch or store must complete in the same cycle
  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    ALUOp     = aluop_nop;
    ASel      = 1'b0;
    BSel      = 1'b0;
    EXTOp     = extop_i;
    rw        = 1'b0;
    WDSel     = wdsel_alu;
    mr        = 1'b0;
    mw        = 1'b0;
    pcw       = 1'b0;
    PCSrc     = pcsrc_pc4;
    if (state == s_exec || state == s_mem || state == s_wb) begin
      ALUOp = dec_aluop;
      ASel  = dec_asel;
      BSel  = dec_bsel;
      EXTOp = dec_extop;
    end
    case (state)
      s_fetch: begin
        rdy = 1'b1;
        if (instr_valid) state_nxt = s_decode;
      end
      s_decode: begin
        if (dec_illegal) state_nxt = TRAP_ON_ILLEGAL ? s_trap : s_wb;
        else             state_nxt = s_exec;
      end
      s_exec: begin
        case (dec_class)
          cls_load, cls_store: state_nxt = s_mem;
          cls_branch: begin
            pcw       = 1'b1;
            PCSrc     = taken ? pcsrc_imm : pcsrc_pc4;
            state_nxt = s_fetch;
          end
          default: state_nxt = s_wb;
        endcase
      end
      s_mem: begin
        if (dec_class == cls_store) begin
          mw  = 1'b1;
          pcw = mem_ready;
          if (mem_ready) state_nxt = s_fetch;
        end else begin
          mr = 1'b1;
          if (mem_ready) state_nxt = s_wb;
        end
      end
      s_wb: begin
        rw  = rd_writes(dec_class) && (ir[11:7] != 5'd0);
        pcw = 1'b1;
        case (dec_class)
          cls_load: WDSel = wdsel_mem;
          cls_jal:  begin WDSel = wdsel_pc4; PCSrc = pcsrc_imm;  end
          cls_jalr: begin WDSel = wdsel_pc4; PCSrc = pcsrc_jalr; end
          default:  WDSel = wdsel_alu;
        endcase
        state_nxt = s_fetch;
      end
      s_trap:  state_nxt = s_trap;
      default: state_nxt = s_fetch;
    endcase
  end

  // reset suppresses every strobe in the same cycle so nothing half-completes
  assign instr_ready = rdy & ~rst;
  assign RegWrite    = rw  & ~rst;
  assign MemRead     = mr  & ~rst;
  assign MemWrite    = mw  & ~rst;
  assign PCWrite     = pcw & ~rst;

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// tb/tb_rv32i_mc_ctrl.sv - directed self-checking bench for rv32i_mc_ctrl
module tb_rv32i_mc_ctrl;

  localparam logic [4:0] op_nop = 5'd0, op_lui = 5'd1, op_add = 5'd3, op_sub = 5'd4;
  localparam logic [4:0] op_slt = 5'd10, op_sltu = 5'd11, op_sra = 5'd17;

  logic        clk = 1'b0;
  logic        rst, instr_valid, Zero, mem_ready;
  logic [31:0] instr;
  logic        instr_ready, ASel, BSel, RegWrite, MemRead, MemWrite, PCWrite, illegal;
  logic [31:0] ir;
  logic [4:0]  ALUOp;
  logic [2:0]  EXTOp;
  logic [1:0]  WDSel, PCSrc;

  int checks = 0;
  int failures = 0;

  rv32i_mc_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .ir(ir), .Zero(Zero), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .ASel(ASel), .BSel(BSel), .EXTOp(EXTOp),
    .RegWrite(RegWrite), .WDSel(WDSel), .MemRead(MemRead), .MemWrite(MemWrite),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present w during a FETCH cycle; returns one cycle into DECODE
  task automatic issue(input logic [31:0] w);
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = 32'h0;
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = 32'h0; Zero = 1'b0; mem_ready = 1'b0;
    step(); step(); #2;
    check("rst_ready", instr_ready, 0);
    check("rst_strobes", {RegWrite, MemRead, MemWrite, PCWrite}, 0);
    check("rst_ir", ir, 32'h00000013);
    check("rst_illegal", illegal, 0);
    rst = 1'b0; #2;
    check("fetch_ready", instr_ready, 1);

    // addi x1,x0,5
    issue(32'h00500093); #2;
    check("addi_dec_ready", instr_ready, 0);
    check("addi_ir", ir, 32'h00500093);
    step(); #2;
    check("addi_aluop", ALUOp, op_add);
    check("addi_sel", {ASel, BSel}, 2'b01);
    check("addi_extop", EXTOp, 0);
    check("addi_exec_pcw", PCWrite, 0);
    step(); #2;
    check("addi_wb", {RegWrite, PCWrite}, 2'b11);
    check("addi_wdsel", WDSel, 0);
    check("addi_pcsrc", PCSrc, 0);
    step(); #2;
    check("addi_latency", instr_ready, 1);

    // beq x0,x0,8 with Zero=1 -> taken
    issue(32'h00000463);
    step(); Zero = 1'b1; #2;
    check("beq_aluop", ALUOp, op_sub);
    check("beq_extop", EXTOp, 2);
    check("beq_pcw", PCWrite, 1);
    check("beq_pcsrc", PCSrc, 1);
    check("beq_regwrite", RegWrite, 0);
    step(); Zero = 1'b0; #2;
    check("beq_latency", instr_ready, 1);

    // bne with Zero=1 -> not taken
    issue(32'h00001463);
    step(); Zero = 1'b1; #2;
    check("bne_aluop", ALUOp, op_sub);
    check("bne_pcsrc", PCSrc, 0);
    check("bne_pcw", PCWrite, 1);
    step(); Zero = 1'b0; #2;

    // blt with Zero=0 -> taken; bgeu with Zero=0 -> not taken
    issue(32'h00004463);
    step(); #2;
    check("blt_aluop", ALUOp, op_slt);
    check("blt_pcsrc", PCSrc, 1);
    step();
    issue(32'h00007463);
    step(); #2;
    check("bgeu_aluop", ALUOp, op_sltu);
    check("bgeu_pcsrc", PCSrc, 0);
    step();

    // sub x3,x1,x2 and srai x1,x1,1
    issue(32'h402081b3);
    step(); #2;
    check("sub_aluop", ALUOp, op_sub);
    check("sub_bsel", BSel, 0);
    step(); step();
    issue(32'h4010d093);
    step(); #2;
    check("srai_aluop", ALUOp, op_sra);
    step(); step();

    // lui x1,0x12345
    issue(32'h123450b7);
    step(); #2;
    check("lui_aluop", ALUOp, op_lui);
    check("lui_extop", EXTOp, 3);
    check("lui_bsel", BSel, 1);
    step(); step();

    // jal x0,8: rd=0 so no register write
    issue(32'h0080006f);
    step(); #2;
    check("jal_extop", EXTOp, 4);
    check("jal_aluop", ALUOp, op_nop);
    step(); #2;
    check("jal_wb", {RegWrite, PCWrite}, 2'b01);
    check("jal_wdsel", WDSel, 2);
    check("jal_pcsrc", PCSrc, 1);
    step();

    // jalr x1,0(x2)
    issue(32'h000100e7);
    step(); step(); #2;
    check("jalr_wb", {RegWrite, PCWrite}, 2'b11);
    check("jalr_wdsel", WDSel, 2);
    check("jalr_pcsrc", PCSrc, 2);
    step();

    // lw x2,0(x1) with two wait cycles
    issue(32'h0000a103);
    step(); #2;
    check("lw_aluop", ALUOp, op_add);
    check("lw_sel", {BSel, EXTOp}, 4'b1000);
    check("lw_exec_mr", MemRead, 0);
    step(); #2;
    check("lw_mr0", MemRead, 1);
    check("lw_mr0_pcw", PCWrite, 0);
    step(); #2;
    check("lw_mr1", MemRead, 1);
    step(); mem_ready = 1'b1; #2;
    check("lw_mr2", MemRead, 1);
    check("lw_mr2_rw", RegWrite, 0);
    step(); mem_ready = 1'b0; #2;
    check("lw_wb_mr", MemRead, 0);
    check("lw_wb", {RegWrite, PCWrite}, 2'b11);
    check("lw_wdsel", WDSel, 1);
    step(); #2;
    check("lw_latency", instr_ready, 1);

    // sw with immediate mem_ready
    issue(32'h0020a023); #2;
    check("sw_dec_rw", RegWrite, 0);
    step(); #2;
    check("sw_extop", EXTOp, 1);
    check("sw_exec", {RegWrite, MemWrite, PCWrite}, 3'b000);
    step(); mem_ready = 1'b1; #2;
    check("sw_mw", MemWrite, 1);
    check("sw_pcw", PCWrite, 1);
    check("sw_pcsrc", PCSrc, 0);
    check("sw_rw", RegWrite, 0);
    step(); mem_ready = 1'b0; #2;
    check("sw_done", {MemWrite, RegWrite, PCWrite}, 3'b000);
    check("sw_latency", instr_ready, 1);

    // illegal opcode traps until reset, ignoring instr_valid
    issue(32'hffffffff);
    step(); instr_valid = 1'b1; #2;
    for (int i = 0; i < 10; i++) begin
      check("trap_illegal", illegal, 1);
      check("trap_ready", instr_ready, 0);
      check("trap_strobes", {RegWrite, MemRead, MemWrite, PCWrite}, 0);
      step(); #2;
    end
    instr_valid = 1'b0; rst = 1'b1;
    step(); rst = 1'b0; #2;
    check("trap_rst_illegal", illegal, 0);
    check("trap_rst_ready", instr_ready, 1);

    // reset during a load's memory wait
    issue(32'h0000a103);
    step(); step(); #2;
    check("mid_mr", MemRead, 1);
    rst = 1'b1; #1;
    check("mid_rst_mr", MemRead, 0);
    step(); rst = 1'b0; #2;
    check("mid_after", {MemRead, PCWrite, RegWrite}, 3'b000);
    check("mid_ir", ir, 32'h00000013);
    check("mid_ready", instr_ready, 1);
    step(); #2;
    check("mid_after2", {MemRead, PCWrite, RegWrite}, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
